// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave and its benches.
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spis_state_t;

    localparam logic [7:0] TX_IDLE_DEFAULT = 8'hA5;

    // Encoding is {CPOL, CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    function automatic bit mode_cpol(input spi_mode_t m);
        return m[1];
    endfunction

    function automatic bit mode_cpha(input spi_mode_t m);
        return m[0];
    endfunction

endpackage

// File: rtl/spi_slave_param_sync_2ff.sv
// Two-flop synchroniser for one asynchronous pin, with a selectable reset level.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave (any CPOL/CPHA, DATA_W-bit words, multi-word frames).
// Optional feature: define SPIS_UNDERRUN_EN to add the tx_underrun pulse output.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int unsigned          DATA_W  = 8,
    parameter bit                   CPOL    = 1'b0,
    parameter bit                   CPHA    = 1'b0,
    parameter logic [DATA_W-1:0]    TX_IDLE = DATA_W'(TX_IDLE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPIS_UNDERRUN_EN
    output logic              frame_active,
    output logic              tx_underrun
`else
    output logic              frame_active
`endif
);

    localparam int unsigned   CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACTIVE = ACTIVE;

    logic              sclk_s;
    logic              cs_n_s;
    logic              mosi_s;
    logic              sclk_d;

    logic [0:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_buf;
    logic              tx_full;
    logic              frame_active_r;

    logic rise;
    logic fall;
    logic lead;
    logic trail;
    logic active;
    logic start;
    logic stop;
    logic run;
    logic sample_e;
    logic shift_e;
    logic load;
    logic word_done;
    logic wr;

    sync_2ff #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (sclk),
        .q   (sclk_s)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs_n (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_n_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d <= CPOL;
        end else begin
            sclk_d <= sclk_s;
        end
    end

    always_comb begin
        rise      = sclk_s & ~sclk_d;
        fall      = ~sclk_s & sclk_d;
        lead      = CPOL ? fall : rise;
        trail     = CPOL ? rise : fall;
        active    = (state == ST_ACTIVE);
        start     = !active && !cs_n_s;
        stop      = active && cs_n_s;
        run       = active && !cs_n_s;
        sample_e  = run && (CPHA ? trail : lead);
        shift_e   = run && (CPHA ? lead : trail);
        word_done = sample_e && (bit_cnt == LAST_BIT);
        // CPHA=0: a shift edge seen with bit_cnt at 0 can only follow a completed word,
        // so it doubles as "first trailing edge after the word"; CPHA=1 loads at bit 0 directly.
        load      = (start && !CPHA) || (shift_e && (bit_cnt == '0));
        wr        = tx_valid && !tx_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            rx_shift       <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            frame_active_r <= 1'b0;
        end else begin
            rx_valid       <= 1'b0;
            frame_active_r <= active;

            if (start) begin
                state <= ST_ACTIVE;
            end

            if (stop) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end

            if (sample_e) begin
                rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
                if (word_done) begin
                    rx_data  <= {rx_shift, mosi_s};
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt  <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // A write can only be accepted while the buffer is empty, so it never collides
    // with a load that drains the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= TX_IDLE;
            tx_buf   <= '0;
            tx_full  <= 1'b0;
        end else begin
            if (load) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    tx_full  <= 1'b0;
                end else begin
                    tx_shift <= TX_IDLE;
                end
            end else if (shift_e) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (wr) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

`ifdef SPIS_UNDERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load && !tx_full;
        end
    end
`endif

    assign tx_ready     = !tx_full;
    assign frame_active = frame_active_r;
    assign miso_oe      = frame_active_r;
    assign miso         = frame_active_r ? tx_shift[DATA_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench: an 8-bit mode-0 slave and a 16-bit mode-3 slave driven by a bit-banged master.
module tb_spi_slave_param;
    import spi_pkg::*;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    logic mosi;

    logic       sclk8, cs_n8, miso8, miso_oe8, tx_valid8, tx_ready8, rx_valid8, fa8;
    logic [7:0] tx_data8, rx_data8;

    logic        sclk16, cs_n16, miso16, miso_oe16, tx_valid16, tx_ready16, rx_valid16, fa16;
    logic [15:0] tx_data16, rx_data16;

`ifdef SPIS_UNDERRUN_EN
    logic udr8, udr16;
    int   udr_cnt16 = 0;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] rx_q8 [$];
    logic [15:0] rx_q16 [$];

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8)) u8 (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk8),
        .cs_n         (cs_n8),
        .mosi         (mosi),
        .miso         (miso8),
        .miso_oe      (miso_oe8),
        .tx_data      (tx_data8),
        .tx_valid     (tx_valid8),
        .tx_ready     (tx_ready8),
        .rx_data      (rx_data8),
        .rx_valid     (rx_valid8),
`ifdef SPIS_UNDERRUN_EN
        .frame_active (fa8),
        .tx_underrun  (udr8)
`else
        .frame_active (fa8)
`endif
    );

    spi_slave_param #(
        .DATA_W (16),
        .CPOL   (mode_cpol(MODE3)),
        .CPHA   (mode_cpha(MODE3))
    ) u16 (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk16),
        .cs_n         (cs_n16),
        .mosi         (mosi),
        .miso         (miso16),
        .miso_oe      (miso_oe16),
        .tx_data      (tx_data16),
        .tx_valid     (tx_valid16),
        .tx_ready     (tx_ready16),
        .rx_data      (rx_data16),
        .rx_valid     (rx_valid16),
`ifdef SPIS_UNDERRUN_EN
        .frame_active (fa16),
        .tx_underrun  (udr16)
`else
        .frame_active (fa16)
`endif
    );

    // Every cycle of rx_valid high logs one entry, so a stretched pulse shows up as extra words
    always @(negedge clk) begin
        if (rx_valid8)  rx_q8.push_back({8'h00, rx_data8});
        if (rx_valid16) rx_q16.push_back(rx_data16);
`ifdef SPIS_UNDERRUN_EN
        if (udr16) udr_cnt16++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit s16, input logic [15:0] val);
        int i;
        i = 0;
        while (i < 200 && !(s16 ? tx_ready16 : tx_ready8)) begin
            @(negedge clk);
            i++;
        end
        check("push_ready_wait", {31'd0, s16 ? tx_ready16 : tx_ready8}, 32'd1);
        if (s16) begin
            tx_data16 = val; tx_valid16 = 1'b1;
        end else begin
            tx_data8 = val[7:0]; tx_valid8 = 1'b1;
        end
        @(negedge clk);
        tx_valid8  = 1'b0;
        tx_valid16 = 1'b0;
    endtask

    task automatic frame_begin(input bit s16);
        if (s16) cs_n16 = 1'b0; else cs_n8 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end(input bit s16);
        repeat (HALF) @(negedge clk);
        if (s16) cs_n16 = 1'b1; else cs_n8 = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Mode 0 on the 8-bit slave, mode 3 on the 16-bit slave; master samples MISO on the sample edge
    task automatic xfer(input bit s16, input int w, input logic [31:0] dout, output logic [31:0] din);
        din = '0;
        for (int i = w - 1; i >= 0; i--) begin
            if (!s16) begin
                mosi = dout[i];
                repeat (HALF) @(negedge clk);
                sclk8 = 1'b1;
                din = {din[30:0], miso8};
                repeat (HALF) @(negedge clk);
                sclk8 = 1'b0;
            end else begin
                sclk16 = 1'b0;
                mosi = dout[i];
                repeat (HALF) @(negedge clk);
                sclk16 = 1'b1;
                din = {din[30:0], miso16};
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] din, din2;
        int base8, base16;

        rst = 1'b1; mosi = 1'b0;
        sclk8 = 1'b0; cs_n8 = 1'b1; tx_valid8 = 1'b0; tx_data8 = '0;
        sclk16 = 1'b1; cs_n16 = 1'b1; tx_valid16 = 1'b0; tx_data16 = '0;
        repeat (3) @(negedge clk);

        check("rst_miso",         {31'd0, miso8},      32'd0);
        check("rst_miso_oe",      {31'd0, miso_oe8},   32'd0);
        check("rst_tx_ready",     {31'd0, tx_ready8},  32'd1);
        check("rst_rx_data",      {24'd0, rx_data8},   32'd0);
        check("rst_rx_valid",     {31'd0, rx_valid8},  32'd0);
        check("rst_frame_active", {31'd0, fa8},        32'd0);
        check("rst_tx_ready16",   {31'd0, tx_ready16}, 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single word, mode 0
        base8 = rx_q8.size();
        push(1'b0, 16'h005A);
        check("t1_tx_ready_low", {31'd0, tx_ready8}, 32'd0);
        frame_begin(1'b0);
        check("t1_frame_active", {31'd0, fa8}, 32'd1);
        check("t1_miso_oe", {31'd0, miso_oe8}, 32'd1);
        check("t1_tx_ready_back", {31'd0, tx_ready8}, 32'd1);
        xfer(1'b0, 8, 32'h3C, din);
        frame_end(1'b0);
        check("t1_rx_count", rx_q8.size() - base8, 32'd1);
        check("t1_rx_data", {24'd0, rx_data8}, 32'h3C);
        check("t1_master_rx", din, 32'h5A);
        check("t1_idle_frame_active", {31'd0, fa8}, 32'd0);

        // Back-to-back words in one frame
        base8 = rx_q8.size();
        push(1'b0, 16'h0011);
        frame_begin(1'b0);
        push(1'b0, 16'h0022);
        xfer(1'b0, 8, 32'hDE, din);
        xfer(1'b0, 8, 32'hAD, din2);
        frame_end(1'b0);
        check("t2_rx_count", rx_q8.size() - base8, 32'd2);
        if (rx_q8.size() >= base8 + 2) begin
            check("t2_rx_word0", {16'd0, rx_q8[base8]},     32'hDE);
            check("t2_rx_word1", {16'd0, rx_q8[base8 + 1]}, 32'hAD);
        end
        check("t2_master_rx0", din,  32'h11);
        check("t2_master_rx1", din2, 32'h22);

        // Mode 3, 16-bit
        base16 = rx_q16.size();
`ifdef SPIS_UNDERRUN_EN
        udr_cnt16 = 0;
`endif
        push(1'b1, 16'hBEEF);
        frame_begin(1'b1);
        xfer(1'b1, 16, 32'h1234, din);
        frame_end(1'b1);
        check("t3_rx_count", rx_q16.size() - base16, 32'd1);
        check("t3_rx_data", {16'd0, rx_data16}, 32'h1234);
        check("t3_master_rx", din, 32'hBEEF);
`ifdef SPIS_UNDERRUN_EN
        check("t3_no_underrun", udr_cnt16, 32'd0);
`endif

        // Underrun: empty buffer at frame start
`ifdef SPIS_UNDERRUN_EN
        udr_cnt16 = 0;
`endif
        frame_begin(1'b1);
        xfer(1'b1, 16, 32'h0F0F, din);
        frame_end(1'b1);
        check("t4_master_rx16_idle", din, 32'h00A5);
        check("t4_rx_data16", {16'd0, rx_data16}, 32'h0F0F);
`ifdef SPIS_UNDERRUN_EN
        check("t4_underrun_pulses", udr_cnt16, 32'd1);
`endif
        frame_begin(1'b0);
        xfer(1'b0, 8, 32'h00, din);
        frame_end(1'b0);
        check("t4_master_rx8_idle", din, 32'hA5);

        // Frame abort after 5 bits; buffered TX word must survive
        base8 = rx_q8.size();
        frame_begin(1'b0);
        push(1'b0, 16'h0066);
        xfer(1'b0, 5, 32'h1F, din);
        frame_end(1'b0);
        check("t5_abort_no_rx", rx_q8.size() - base8, 32'd0);
        check("t5_abort_bit_cnt", {29'd0, u8.bit_cnt}, 32'd0);
        check("t5_abort_tx_kept", {31'd0, tx_ready8}, 32'd0);
        frame_begin(1'b0);
        xfer(1'b0, 8, 32'h81, din);
        frame_end(1'b0);
        check("t5_rx_count", rx_q8.size() - base8, 32'd1);
        check("t5_rx_data", {24'd0, rx_data8}, 32'h81);
        check("t5_master_rx", din, 32'h66);

        // Reset mid-frame
        frame_begin(1'b0);
        push(1'b0, 16'h0044);
        xfer(1'b0, 3, 32'h5, din);
        rst = 1'b1;
        #1;
        check("t6_miso",         {31'd0, miso8},     32'd0);
        check("t6_miso_oe",      {31'd0, miso_oe8},  32'd0);
        check("t6_tx_ready",     {31'd0, tx_ready8}, 32'd1);
        check("t6_rx_data",      {24'd0, rx_data8},  32'd0);
        check("t6_rx_valid",     {31'd0, rx_valid8}, 32'd0);
        check("t6_frame_active", {31'd0, fa8},       32'd0);
        cs_n8 = 1'b1;
        sclk8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        base8 = rx_q8.size();
        push(1'b0, 16'h00C3);
        frame_begin(1'b0);
        xfer(1'b0, 8, 32'h96, din);
        frame_end(1'b0);
        check("t6_rx_count", rx_q8.size() - base8, 32'd1);
        check("t6_rx_data_after", {24'd0, rx_data8}, 32'h96);
        check("t6_master_rx", din, 32'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
